// File: rtl/binupcnt.sv
// -----------------------------------------------------------------------------
// binupcnt -- WIDTH-bit unsigned binary up-counter with parallel load.
//
// Each rising clk edge applies exactly one action, highest priority first:
//   reset (rst_n = 1) -> q = 0
//   load              -> q = d
//   en                -> q = q + 1 (wraps, or saturates, see below)
//   otherwise         -> q holds
//
// Configuration macro:
//   BINUPCNT_SATURATE_EN  when defined, an increment at all-ones holds q at
//                         all-ones instead of wrapping to zero. Load, reset
//                         and tc are the same in both builds.
//
// Ports:
//   clk    in   1      clock, all state updates on its rising edge
//   rst_n  in   1      synchronous reset, ACTIVE-HIGH despite the name
//   en     in   1      count enable
//   load   in   1      parallel-load strobe, wins over en
//   d      in   WIDTH  parallel-load value
//   q      out  WIDTH  current count, straight from the register
//   tc     out  1      terminal count, combinational, 1 while q is all-ones
// -----------------------------------------------------------------------------
module binupcnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Terminal-count detect, shared by tc and the saturate guard.
  function automatic logic is_all_ones(input logic [WIDTH-1:0] value);
    return (value == ALL_ONES);
  endfunction

  logic [WIDTH-1:0] q_next_s;

  // Next-count selection for the non-reset case (load over en over hold).
  always_comb begin
    q_next_s = q;
    if (load) begin
      q_next_s = d;
    end else if (en) begin
`ifdef BINUPCNT_SATURATE_EN
      if (is_all_ones(q)) begin
        q_next_s = q;
      end else begin
        q_next_s = q + ONE;
      end
`else
      // Natural modulo-2^WIDTH wrap from the truncated add.
      q_next_s = q + ONE;
`endif
    end else begin
      q_next_s = q;
    end
  end

  // Count register; reset is sampled on the clock edge and overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= q_next_s;
    end
  end

  // tc follows q directly, independent of en.
  assign tc = is_all_ones(q);

endmodule

// File: tb/tb_binupcnt.sv
// -----------------------------------------------------------------------------
// tb_binupcnt -- scoreboard bench for binupcnt (WIDTH = 4).
// The driver applies one input vector per cycle on the falling edge and pushes
// the hand-computed q expected after the next rising edge; a separate monitor
// pops one entry per rising edge and compares q and tc.
// -----------------------------------------------------------------------------
module tb_binupcnt;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;

  int checks;
  int errors;

  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  binupcnt #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .d     (d),
    .q     (q),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per rising edge while the scoreboard holds any.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      checks++;
      if (q !== mon_exp) begin
        errors++;
        $display("FAIL q_value t=%0t got %0d expected %0d", $time, q, mon_exp);
      end
      checks++;
      if (tc !== (mon_exp == 4'hF)) begin
        errors++;
        $display("FAIL tc_value t=%0t q_exp=%0d got %0b expected %0b",
                 $time, mon_exp, tc, (mon_exp == 4'hF));
      end
    end
  end

  // Apply one vector on the falling edge and record the resulting q.
  task automatic step(input logic r, input logic l, input logic [3:0] dv,
                      input logic e, input logic [3:0] expect_q);
    @(negedge clk);
    rst_n = r;
    load  = l;
    d     = dv;
    en    = e;
    exp_q.push_back(expect_q);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    d      = 4'd0;

    // Reset from unknown; load/en active on the reset edge must be ignored.
    step(1'b1, 1'b1, 4'd7, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd2);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd3);

    // Load beats en, then counting continues from the loaded value.
    step(1'b0, 1'b1, 4'd9, 1'b1, 4'd9);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd10);

    // Hold at 6 for five edges.
    step(1'b0, 1'b1, 4'd6, 1'b0, 4'd6);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd3, 1'b0, 4'd6);

    // Free run from 0 for 16 edges.
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    for (int i = 1; i <= 15; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 4'(i));
`ifdef BINUPCNT_SATURATE_EN
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
`else
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
`endif

    // Synchronous reset mid-count, asserted between edges with a load pending.
    step(1'b0, 1'b1, 4'd12, 1'b0, 4'd12);
    step(1'b1, 1'b1, 4'd5, 1'b1, 4'd0);
    #1;
    checks++;
    if (q !== 4'd12) begin
      errors++;
      $display("FAIL rst_between_edges got %0d expected %0d", q, 4'd12);
    end
    // Counting resumes on the first edge after reset drops.
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd2);

    // Terminal-count behaviour from 14.
    step(1'b0, 1'b1, 4'd14, 1'b0, 4'd14);
`ifdef BINUPCNT_SATURATE_EN
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
`else
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
`endif

    // Load at all-ones with en low, then hold there.
    step(1'b0, 1'b1, 4'd15, 1'b0, 4'd15);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd15);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd15);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binupcnt.md
BINUPCNT -- requirements
Module: binupcnt

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter bit width; legal values are 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous reset, active-high; 1 = reset asserted, sampled on the rising edge of clk.
REQ-004 The module SHALL have port en, input, 1 bit: count enable; 1 = increment.
REQ-005 The module SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-006 The module SHALL have port d, input, WIDTH bits: parallel-load value.
REQ-007 The module SHALL have port q, output, WIDTH bits: current count, driven directly from a register.
REQ-008 The module SHALL have port tc, output, 1 bit: terminal count, combinational, 1 when q equals all-ones.

Function
REQ-009 The count SHALL be an unsigned binary value, WIDTH bits.
REQ-010 Each rising clk edge SHALL apply exactly one action, chosen by this priority:
  - rst_n = 1: q <= 0.
  - else load = 1: q <= d.
  - else en = 1: q <= q + 1, modulo 2^WIDTH.
  - else: q holds.
REQ-011 An increment SHALL have one-cycle latency: the new q is visible after the same edge that sampled en = 1.
REQ-012 A load SHALL have one-cycle latency and SHALL take priority over en when both are 1.
REQ-013 Wrap-around (default build): with q = 2^WIDTH-1 and en = 1, the next q SHALL be 0.
REQ-014 tc SHALL be 1 exactly while q = 2^WIDTH-1 and 0 otherwise, independent of en.
REQ-015 The module SHALL contain no internal state other than the q register.
REQ-016 Inputs other than rst_n SHALL have no effect on the edge where rst_n = 1.

Reset
REQ-017 Reset SHALL be synchronous: asserting rst_n between edges SHALL NOT change q until the next rising clk edge.
REQ-018 The reset value SHALL be q = 0, which gives tc = 0.
REQ-019 Reset asserted in the middle of counting SHALL force q = 0 on the next edge, overriding load and en.
REQ-020 Counting SHALL resume on the first edge after rst_n returns to 0, provided en = 1.
REQ-021 Before the first reset, q SHALL be undefined and SHALL NOT be relied upon.

Configuration
REQ-022 Macro BINUPCNT_SATURATE_EN SHALL select the behaviour at the terminal count.
  - With the macro defined: at q = 2^WIDTH-1 with en = 1 and load = 0, q SHALL hold at all-ones; load and reset SHALL behave unchanged.
  - With the macro undefined (default): q SHALL wrap to 0 as in REQ-013.
REQ-023 tc SHALL behave identically in both builds.

Verification
REQ-024 Reset from unknown state, WIDTH=4:
  - Stimulus: rst_n = 1 for one edge, then rst_n = 0, en = 1.
  - Required: q = 0 after the first edge; q = 1, 2, 3 on the following edges.
REQ-025 Free-run wrap, default build:
  - Stimulus: en = 1 held for 16 edges from q = 0.
  - Required: q steps 0..15 and returns to 0; tc = 1 only while q = 15.
REQ-026 Load priority:
  - Stimulus: q = 3, load = 1, d = 9, en = 1.
  - Required: q = 9 on the next edge; with en = 1 and load = 0 afterwards, q = 10 on the following edge.
REQ-027 Hold:
  - Stimulus: en = 0, load = 0 for 5 edges at q = 6.
  - Required: q remains 6 throughout.
REQ-028 Synchronous reset mid-count:
  - Stimulus: q = 12; assert rst_n between edges together with load = 1, d = 5.
  - Required: q = 12 until the next edge, then q = 0.
REQ-029 Saturate build (BINUPCNT_SATURATE_EN defined):
  - Stimulus: q = 14, en = 1 for 3 edges.
  - Required: q = 15, 15, 15; tc stays 1.
